mix_columns_ctrl: RTL

Column-serial MixColumns/AddRoundKey round stage for the two-share threshold AES datapath. It sits directly downstream of SubBytes. It captures both 128-bit state shares and both round-key shares, then processes one column per cycle through a per-share linear MixColumns. The two shares of the next round state are presented on a valid/ready handshake.

---
 rtl/aes_ti_pkg.sv | 108 ++++++++++
 rtl/mc_column_share.sv | 25 ++
 rtl/mix_columns_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/aes_ti_pkg.sv
// ---------------------------------------------------------------------------
// aes_ti_pkg
//   Shared types and helpers for the two-share threshold AES datapath.
//   - block_t / column_t / byte_t     : 128/32/8-bit state containers
//   - block_bytes_t                   : byte view of a block, byte 0 = [127:120]
//   - state_e                         : MixColumns stage FSM states
//   - byte_idx / sr_src_idx           : FIPS-197 byte index helpers
//   - shift_rows                      : ShiftRows permutation (used when
//                                       MC_SHIFTROWS_EN folds it into capture)
//   - get_column / put_column         : column extract / insert
//   - xtime / mix_column              : GF(2^8) column MixColumns
// ---------------------------------------------------------------------------
package aes_ti_pkg;

  localparam int BYTE_W    = 8;
  localparam int NUM_ROWS  = 4;
  localparam int NUM_COLS  = 4;
  localparam int NUM_BYTES = NUM_ROWS * NUM_COLS;

  typedef logic [127:0]       block_t;
  typedef logic [31:0]        column_t;
  typedef logic [BYTE_W-1:0]  byte_t;
  typedef logic [1:0]         col_idx_t;

  // Packed with ascending byte index so element 0 lands on bits [127:120].
  typedef logic [0:NUM_BYTES-1][BYTE_W-1:0] block_bytes_t;

  localparam col_idx_t COL_FIRST = 2'd0;
  localparam col_idx_t COL_LAST  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Byte index of (row r, column c).
  function automatic logic [3:0] byte_idx(input int r, input int c);
    return 4'(NUM_ROWS * c + r);
  endfunction

  // Source byte for ShiftRows output (row r, column c): row r rotated left by r.
  function automatic logic [3:0] sr_src_idx(input int r, input int c);
    return byte_idx(r, (c + r) % NUM_COLS);
  endfunction

  function automatic block_t shift_rows(input block_t b);
    block_bytes_t src;
    block_bytes_t dst;
    src = b;
    dst = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        dst[byte_idx(r, c)] = src[sr_src_idx(r, c)];
      end
    end
    return dst;
  endfunction

  function automatic column_t get_column(input block_t b, input col_idx_t c);
    column_t col;
    col = '0;
    case (c)
      2'd0: col = b[127:96];
      2'd1: col = b[95:64];
      2'd2: col = b[63:32];
      2'd3: col = b[31:0];
      default: col = '0;
    endcase
    return col;
  endfunction

  function automatic block_t put_column(input block_t b, input col_idx_t c,
                                        input column_t v);
    block_t res;
    res = b;
    case (c)
      2'd0: res[127:96] = v;
      2'd1: res[95:64]  = v;
      2'd2: res[63:32]  = v;
      2'd3: res[31:0]   = v;
      default: res = b;
    endcase
    return res;
  endfunction

  // Multiply by x in GF(2^8) with the AES polynomial.
  function automatic byte_t xtime(input byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns on one column; row 0 is the most significant byte. Linear, so
  // it can be applied to each share independently.
  function automatic column_t mix_column(input column_t x);
    byte_t a0, a1, a2, a3;
    byte_t b0, b1, b2, b3;
    a0 = x[31:24];
    a1 = x[23:16];
    a2 = x[15:8];
    a3 = x[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/mc_column_share.sv
// ---------------------------------------------------------------------------
// mc_column_share
//   Per-share column datapath: MixColumns (or bypass in the last round)
//   followed by the round-key column XOR. Purely combinational.
//   Ports:
//     col_in     in  32  working-state column of this share
//     key_in     in  32  round-key column of this share
//     last_round in  1   1 = skip MixColumns
//     col_out    out 32  next-round column of this share
// ---------------------------------------------------------------------------
module mc_column_share
  import aes_ti_pkg::*;
(
  input  column_t col_in,
  input  column_t key_in,
  input  logic    last_round,
  output column_t col_out
);

  column_t mixed;

  assign mixed   = last_round ? col_in : mix_column(col_in);
  assign col_out = mixed ^ key_in;

endmodule

// File: rtl/mix_columns_ctrl.sv
// ---------------------------------------------------------------------------
// mix_columns_ctrl
//   Column-serial MixColumns/AddRoundKey stage for the two-share threshold
//   AES datapath. Captures both state shares and both key shares, then
//   processes one column per cycle (4 cycles) and holds the two result shares
//   on a valid/ready handshake. Shares never mix.
//   Ports:
//     ClkxCI        in  1    clock, rising edge
//     RstxRI        in  1    asynchronous active-high reset
//     InValidxSI    in  1    upstream block valid
//     InReadyxSO    out 1    stage idle, can accept
//     LastRoundxSI  in  1    sampled with the block, 1 = bypass MixColumns
//     S0xDI, S1xDI  in  128  state shares after SubBytes
//     K0xDI, K1xDI  in  128  round-key shares
//     OutValidxSO   out 1    result valid
//     OutReadyxSI   in  1    downstream accepts result
//     Q0xDO, Q1xDO  out 128  registered result shares
//   Configuration:
//     MC_SHIFTROWS_EN  defined   -> ShiftRows applied to the state at capture
//                      undefined -> state captured unpermuted
// ---------------------------------------------------------------------------
module mix_columns_ctrl
  import aes_ti_pkg::*;
(
  input  logic   ClkxCI,
  input  logic   RstxRI,
  input  logic   InValidxSI,
  output logic   InReadyxSO,
  input  logic   LastRoundxSI,
  input  block_t S0xDI,
  input  block_t S1xDI,
  input  block_t K0xDI,
  input  block_t K1xDI,
  output logic   OutValidxSO,
  input  logic   OutReadyxSI,
  output block_t Q0xDO,
  output block_t Q1xDO
);

  state_e   state_q, state_d;
  col_idx_t col_q;
  logic     last_q;
  block_t   s0_q, s1_q, k0_q, k1_q;
  block_t   q0_q, q1_q;
  logic     accept;
  block_t   s0_cap, s1_cap;
  column_t  col0_out, col1_out;

  assign accept = (state_q == ST_IDLE) && InValidxSI;

`ifdef MC_SHIFTROWS_EN
  // Working byte (r, c) takes input byte (r, (c+r) mod 4); key is untouched.
  assign s0_cap = shift_rows(S0xDI);
  assign s1_cap = shift_rows(S1xDI);
`else
  assign s0_cap = S0xDI;
  assign s1_cap = S1xDI;
`endif

  // ---------------------------------------------------------------- FSM ---
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (InValidxSI)         state_d = ST_BUSY;
      ST_BUSY: if (col_q == COL_LAST)  state_d = ST_DONE;
      ST_DONE: if (OutReadyxSI)        state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Outputs decode only the state register: no input-to-output comb path.
  always_comb begin
    InReadyxSO  = 1'b0;
    OutValidxSO = 1'b0;
    case (state_q)
      ST_IDLE: InReadyxSO  = 1'b1;
      ST_DONE: OutValidxSO = 1'b1;
      default: ;
    endcase
  end

  // ----------------------------------------------------------- datapath ---
  mc_column_share u_share0 (
    .col_in     (get_column(s0_q, col_q)),
    .key_in     (get_column(k0_q, col_q)),
    .last_round (last_q),
    .col_out    (col0_out)
  );

  mc_column_share u_share1 (
    .col_in     (get_column(s1_q, col_q)),
    .key_in     (get_column(k1_q, col_q)),
    .last_round (last_q),
    .col_out    (col1_out)
  );

  // All working, key and output registers are cleared on reset so an aborted
  // block leaves no share material behind.
  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      col_q  <= COL_FIRST;
      last_q <= 1'b0;
      s0_q   <= '0;
      s1_q   <= '0;
      k0_q   <= '0;
      k1_q   <= '0;
      q0_q   <= '0;
      q1_q   <= '0;
    end else if (accept) begin
      col_q  <= COL_FIRST;
      last_q <= LastRoundxSI;
      s0_q   <= s0_cap;
      s1_q   <= s1_cap;
      k0_q   <= K0xDI;
      k1_q   <= K1xDI;
    end else if (state_q == ST_BUSY) begin
      // Counter wraps from 3 back to 0 on the final column.
      col_q <= col_q + 2'd1;
      q0_q  <= put_column(q0_q, col_q, col0_out);
      q1_q  <= put_column(q1_q, col_q, col1_out);
    end
  end

  assign Q0xDO = q0_q;
  assign Q1xDO = q1_q;

endmodule
